// File: rtl/mod_147_10_hb_ctrl.sv
// Point-to-point heartbeat controller with internal timers,
// bounded master collision retry and follower loss watchdog.
module mod_147_10_hb_ctrl #(
   parameter int unsigned HB_PERIOD   = 64,
   parameter int unsigned HB_SEND     = 8,
   parameter int unsigned MAX_COLL    = 4,
   parameter int unsigned MISS_CYCLES = 256,
   parameter int unsigned MISS_LIMIT  = 3,
   parameter int unsigned CNT_W       = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       pcs_reset,
   input  logic       mr_autoneg_enable,
   input  logic       an_link_good,
   input  logic       multidrop,
   input  logic [1:0] rx_cmd,
   input  logic [1:0] tx_cmd,
   input  logic       master,
   input  logic       CRS,
   input  logic       COL,
   input  logic       RX_DV,
   output logic [1:0] hb_cmd,
   output logic [3:0] hb_state,
   output logic [3:0] coll_cnt,
   output logic       coll_abort,
   output logic       hb_lost
);

   typedef enum logic [3:0] {
      INIT       = 4'd0,
      WAIT_TMR   = 4'd1,
      DISABLE_HB = 4'd2,
      TX_HB      = 4'd3,
      COLLIDE    = 4'd4,
      COOLDOWN   = 4'd5,
      WAIT_HB    = 4'd6,
      WAIT_TX    = 4'd7,
      WAIT_RX    = 4'd8,
      REPLY_HB   = 4'd9
   } state_t;

   localparam logic [1:0] CMD_BEACON = 2'b00;
   localparam logic [1:0] CMD_HB     = 2'b10;
   localparam logic [1:0] CMD_NONE   = 2'b11;

   localparam logic [CNT_W-1:0] LD_PERIOD = CNT_W'(HB_PERIOD - 1);
   localparam logic [CNT_W-1:0] LD_SEND   = CNT_W'(HB_SEND - 1);
   localparam logic [CNT_W-1:0] LD_MISS   = CNT_W'(MISS_CYCLES - 1);
   localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
   localparam logic [3:0]       MAX_C     = 4'(MAX_COLL);
   localparam logic [3:0]       LIM       = 4'(MISS_LIMIT);

   state_t           state, state_n;
   logic [CNT_W-1:0] timer, timer_n;
   logic [CNT_W-1:0] wd, wd_n;
   logic [3:0]       coll_n;
   logic [3:0]       miss_cnt, miss_n;
   logic             abort_n;
   logic             lost_n;
   logic             en;
   logic             beacon;
   logic             done;

   assign en     = !pcs_reset && mr_autoneg_enable
                   && an_link_good && !multidrop;
   assign beacon = (rx_cmd == CMD_BEACON) || (tx_cmd == CMD_BEACON);
   assign done   = (timer == '0);

   always_comb begin
      state_n = state;
      coll_n  = coll_cnt;
      miss_n  = miss_cnt;
      lost_n  = hb_lost;
      abort_n = 1'b0;
      if (!en) begin
         state_n = INIT;
         coll_n  = '0;
         miss_n  = '0;
         lost_n  = 1'b0;
      end else if (beacon) begin
         state_n = DISABLE_HB;
      end else begin
         unique case (state)
            INIT: state_n = master ? WAIT_TMR : WAIT_HB;
            WAIT_TMR: begin
               if (done && !CRS) state_n = TX_HB;
            end
            TX_HB: begin
               if (COL) begin
                  state_n = COLLIDE;
                  coll_n  = coll_cnt + 4'd1;
               end else if (done) begin
                  state_n = WAIT_TMR;
                  coll_n  = '0;
               end
            end
            COLLIDE: begin
               if (!CRS) begin
                  if (coll_cnt < MAX_C) begin
                     state_n = COOLDOWN;
                  end else begin
                     state_n = WAIT_TMR;
                     abort_n = 1'b1;
                     coll_n  = '0;
                  end
               end
            end
            COOLDOWN: begin
               if (done) state_n = TX_HB;
            end
            WAIT_HB: begin
               if (rx_cmd == CMD_HB || RX_DV) begin
                  state_n = WAIT_RX;
                  miss_n  = '0;
                  lost_n  = 1'b0;
               end else if (wd == '0) begin
                  if (miss_cnt != LIM) miss_n = miss_cnt + 4'd1;
                  lost_n = hb_lost || (miss_n == LIM);
               end
            end
            WAIT_RX: begin
               if (!CRS) state_n = WAIT_TX;
            end
            WAIT_TX: begin
               if (done) state_n = REPLY_HB;
            end
            REPLY_HB: begin
               if (done) state_n = WAIT_HB;
            end
            DISABLE_HB: state_n = DISABLE_HB;
            default: state_n = INIT;
         endcase
      end
   end

   // Shared dwell timer; reloaded whenever a new state is entered.
   always_comb begin
      timer_n = timer;
      if (state != WAIT_HB && timer != '0) timer_n = timer - ONE;
      if (state_n != state) begin
         unique case (state_n)
            WAIT_TMR: timer_n = LD_PERIOD;
            TX_HB, COOLDOWN, WAIT_TX, REPLY_HB: timer_n = LD_SEND;
            default: timer_n = timer_n;
         endcase
      end
   end

   // Watchdog window only advances while waiting for a heartbeat.
   always_comb begin
      wd_n = wd;
      if (state == WAIT_HB) wd_n = (wd == '0) ? LD_MISS : wd - ONE;
      if (state_n == WAIT_HB && state != WAIT_HB) wd_n = LD_MISS;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= INIT;
         timer      <= '0;
         wd         <= '0;
         coll_cnt   <= '0;
         miss_cnt   <= '0;
         coll_abort <= 1'b0;
         hb_lost    <= 1'b0;
      end else begin
         state      <= state_n;
         timer      <= timer_n;
         wd         <= wd_n;
         coll_cnt   <= coll_n;
         miss_cnt   <= miss_n;
         coll_abort <= abort_n;
         hb_lost    <= lost_n;
      end
   end

   assign hb_state = state;
   assign hb_cmd   = (state == TX_HB || state == REPLY_HB) ? CMD_HB : CMD_NONE;

endmodule

// File: tb/tb_mod_147_10_hb_ctrl.sv
// Bench for mod_147_10_hb_ctrl: dwell-age reference model
// compared every cycle, plus directed literal checkpoints.
module tb_mod_147_10_hb_ctrl;

   localparam int HB_PERIOD   = 8;
   localparam int HB_SEND     = 3;
   localparam int MAX_COLL    = 2;
   localparam int MISS_CYCLES = 10;
   localparam int MISS_LIMIT  = 3;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       pcs_reset = 1'b0;
   logic       mr_autoneg_enable = 1'b1;
   logic       an_link_good = 1'b1;
   logic       multidrop = 1'b0;
   logic [1:0] rx_cmd = 2'b11;
   logic [1:0] tx_cmd = 2'b11;
   logic       master = 1'b1;
   logic       CRS = 1'b0;
   logic       COL = 1'b0;
   logic       RX_DV = 1'b0;
   logic [1:0] hb_cmd;
   logic [3:0] hb_state;
   logic [3:0] coll_cnt;
   logic       coll_abort;
   logic       hb_lost;

   int checks = 0;
   int errors = 0;
   bit started = 1'b0;

   mod_147_10_hb_ctrl #(
      .HB_PERIOD(HB_PERIOD), .HB_SEND(HB_SEND), .MAX_COLL(MAX_COLL),
      .MISS_CYCLES(MISS_CYCLES), .MISS_LIMIT(MISS_LIMIT), .CNT_W(16)
   ) dut (
      .clk(clk), .reset(reset), .pcs_reset(pcs_reset),
      .mr_autoneg_enable(mr_autoneg_enable),
      .an_link_good(an_link_good), .multidrop(multidrop),
      .rx_cmd(rx_cmd), .tx_cmd(tx_cmd), .master(master),
      .CRS(CRS), .COL(COL), .RX_DV(RX_DV),
      .hb_cmd(hb_cmd), .hb_state(hb_state), .coll_cnt(coll_cnt),
      .coll_abort(coll_abort), .hb_lost(hb_lost)
   );

   always #5 clk = ~clk;

   // Reference model: tracks how long each state has been occupied
   // and how far into the current watchdog window the follower is.
   int m_st, m_age, m_coll, m_miss, m_wd;
   bit m_abort, m_lost;
   int n_st, n_coll, n_miss, n_wd;
   bit n_abort, n_lost;
   bit m_en;

   always_comb begin
      n_st    = m_st;
      n_coll  = m_coll;
      n_miss  = m_miss;
      n_lost  = m_lost;
      n_abort = 1'b0;
      n_wd    = m_wd;
      m_en = !pcs_reset && mr_autoneg_enable && an_link_good && !multidrop;
      if (!m_en) begin
         n_st = 0; n_coll = 0; n_miss = 0; n_lost = 1'b0;
      end else if (rx_cmd == 2'b00 || tx_cmd == 2'b00) begin
         n_st = 2;
      end else begin
         case (m_st)
            0: n_st = master ? 1 : 6;
            1: if (m_age >= HB_PERIOD - 1 && !CRS) n_st = 3;
            3: if (COL) begin
                  n_st = 4; n_coll = m_coll + 1;
               end else if (m_age >= HB_SEND - 1) begin
                  n_st = 1; n_coll = 0;
               end
            4: if (!CRS) begin
                  if (m_coll < MAX_COLL) n_st = 5;
                  else begin n_st = 1; n_abort = 1'b1; n_coll = 0; end
               end
            5: if (m_age >= HB_SEND - 1) n_st = 3;
            6: if (rx_cmd == 2'b10 || RX_DV) begin
                  n_st = 8; n_miss = 0; n_lost = 1'b0;
               end else if (m_wd == MISS_CYCLES - 1) begin
                  n_wd = 0;
                  if (m_miss < MISS_LIMIT) n_miss = m_miss + 1;
                  if (n_miss >= MISS_LIMIT) n_lost = 1'b1;
               end else begin
                  n_wd = m_wd + 1;
               end
            8: if (!CRS) n_st = 7;
            7: if (m_age >= HB_SEND - 1) n_st = 9;
            9: if (m_age >= HB_SEND - 1) n_st = 6;
            default: n_st = m_st;
         endcase
      end
      if (n_st == 6 && m_st != 6) n_wd = 0;
   end

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_st <= 0; m_age <= 0; m_coll <= 0; m_miss <= 0;
         m_wd <= 0; m_abort <= 1'b0; m_lost <= 1'b0;
      end else begin
         m_st    <= n_st;
         m_age   <= (n_st == m_st) ? m_age + 1 : 0;
         m_coll  <= n_coll;
         m_miss  <= n_miss;
         m_wd    <= n_wd;
         m_abort <= n_abort;
         m_lost  <= n_lost;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (started) begin
         chk("cmp_state", 32'(hb_state), 32'(m_st));
         chk("cmp_cmd", 32'(hb_cmd), (m_st == 3 || m_st == 9) ? 32'd2 : 32'd3);
         chk("cmp_coll", 32'(coll_cnt), 32'(m_coll));
         chk("cmp_abort", 32'(coll_abort), 32'(m_abort));
         chk("cmp_lost", 32'(hb_lost), 32'(m_lost));
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   initial begin
      #1 reset = 1'b1;
      started = 1'b1;
      @(posedge clk); #2;
      chk("rst_state", 32'(hb_state), 32'd0);
      chk("rst_cmd", 32'(hb_cmd), 32'd3);
      chk("rst_coll", 32'(coll_cnt), 32'd0);
      chk("rst_abort", 32'(coll_abort), 32'd0);
      chk("rst_lost", 32'(hb_lost), 32'd0);
      reset = 1'b0;

      // master heartbeat period
      step(1);  chk("t1_wait_tmr", 32'(hb_state), 32'd1);
      step(7);  chk("t1_wait_end", 32'(hb_state), 32'd1);
      step(1);  chk("t1_tx_hb", 32'(hb_state), 32'd3);
      chk("t1_hb_cmd", 32'(hb_cmd), 32'd2);
      step(3);  chk("t1_back_wait", 32'(hb_state), 32'd1);
      step(8);  chk("t1_tx_hb2", 32'(hb_state), 32'd3);

      // two collisions -> abort
      COL = 1'b1; CRS = 1'b1;
      step(1);  chk("t2_collide1", 32'(hb_state), 32'd4);
      chk("t2_cnt1", 32'(coll_cnt), 32'd1);
      COL = 1'b0;
      step(1);  CRS = 1'b0;
      step(1);  chk("t2_cooldown", 32'(hb_state), 32'd5);
      step(3);  chk("t2_retry", 32'(hb_state), 32'd3);
      COL = 1'b1; CRS = 1'b1;
      step(1);  chk("t2_cnt2", 32'(coll_cnt), 32'd2);
      COL = 1'b0;
      step(1);  CRS = 1'b0;
      step(1);  chk("t2_abort", 32'(coll_abort), 32'd1);
      chk("t2_abort_state", 32'(hb_state), 32'd1);
      chk("t2_cnt_clr", 32'(coll_cnt), 32'd0);
      step(1);  chk("t2_abort_pulse", 32'(coll_abort), 32'd0);
      step(6);  chk("t2_no_early_tx", 32'(hb_state), 32'd1);
      step(1);  chk("t2_tx_after", 32'(hb_state), 32'd3);

      // beacon during TX_HB, then link loss
      rx_cmd = 2'b00;
      step(1);  chk("t5_disable", 32'(hb_state), 32'd2);
      chk("t5_cmd_none", 32'(hb_cmd), 32'd3);
      rx_cmd = 2'b11;
      step(3);  chk("t5_stays", 32'(hb_state), 32'd2);
      an_link_good = 1'b0;
      step(1);  chk("t5_init", 32'(hb_state), 32'd0);
      rx_cmd = 2'b00;
      step(1);  chk("t5_init_wins", 32'(hb_state), 32'd0);
      rx_cmd = 2'b11;

      // follower reply
      master = 1'b0; an_link_good = 1'b1;
      step(1);  chk("t3_wait_hb", 32'(hb_state), 32'd6);
      rx_cmd = 2'b10;
      step(1);  chk("t3_wait_rx", 32'(hb_state), 32'd8);
      rx_cmd = 2'b11; CRS = 1'b1;
      step(3);  chk("t3_hold_rx", 32'(hb_state), 32'd8);
      CRS = 1'b0;
      step(1);  chk("t3_wait_tx", 32'(hb_state), 32'd7);
      step(2);  chk("t3_wait_tx_end", 32'(hb_state), 32'd7);
      step(1);  chk("t3_reply", 32'(hb_state), 32'd9);
      chk("t3_reply_cmd", 32'(hb_cmd), 32'd2);
      step(2);  chk("t3_reply_end", 32'(hb_cmd), 32'd2);
      step(1);  chk("t3_back_hb", 32'(hb_state), 32'd6);

      // watchdog
      step(29); chk("t4_not_lost", 32'(hb_lost), 32'd0);
      step(1);  chk("t4_lost", 32'(hb_lost), 32'd1);
      step(10); chk("t4_sticky", 32'(hb_lost), 32'd1);
      RX_DV = 1'b1;
      step(1);  chk("t4_cleared", 32'(hb_lost), 32'd0);
      chk("t4_rx_state", 32'(hb_state), 32'd8);
      RX_DV = 1'b0;

      // async reset during REPLY_HB
      step(1);  step(3);
      chk("t6_in_reply", 32'(hb_state), 32'd9);
      reset = 1'b1;
      #1;
      chk("t6_async_state", 32'(hb_state), 32'd0);
      chk("t6_async_cmd", 32'(hb_cmd), 32'd3);
      step(2);
      reset = 1'b0;
      step(1);  chk("t6_restart", 32'(hb_state), 32'd6);
      step(2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
